// File: rtl/yhat_sched_if.sv
// Handshake and datapath bus of the y_hat scheduler: input beats, cal_yhat drive/return, frame output.
interface yhat_sched_if;
  localparam int unsigned VEC_W = 192;
  localparam int unsigned YH_W  = 40;
  localparam int unsigned OUT_W = 160;

  logic              i_in_valid;
  logic              o_in_ready;
  logic [VEC_W-1:0]  i_q_col;
  logic [VEC_W-1:0]  i_y;
  logic              o_dp_en;
  logic [VEC_W-1:0]  o_dp_e;
  logic [VEC_W-1:0]  o_dp_y;
  logic [YH_W-1:0]   i_dp_yhat;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [OUT_W-1:0]  o_yhat;

  modport master (
    output i_in_valid, i_q_col, i_y, i_dp_yhat, i_out_ready,
    input  o_in_ready, o_dp_en, o_dp_e, o_dp_y, o_out_valid, o_yhat
  );

  modport slave (
    input  i_in_valid, i_q_col, i_y, i_dp_yhat, i_out_ready,
    output o_in_ready, o_dp_en, o_dp_e, o_dp_y, o_out_valid, o_yhat
  );
endinterface

// File: rtl/yhat_sched.sv
// Frame scheduler for cal_yhat: buffers 4 Q columns plus y, streams them to the datapath
// and collects the 4 y_hat results into one output frame.
module yhat_sched #(
  parameter int unsigned NCOL   = 4,
  parameter int unsigned DP_LAT = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  yhat_sched_if.slave bus
);
  localparam int unsigned CW       = 48;
  localparam int unsigned VW       = NCOL * CW;
  localparam int unsigned YW       = 40;
  localparam int unsigned RW       = 4;
  localparam int unsigned RUN_LAST = 2 * NCOL + 3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [RW-1:0]            r_q, r_d;
  logic                     accept_c;
  logic [NCOL-1:0][VW-1:0]  col_q;
  logic [VW-1:0]            y_q;
  logic [RW-1:0]            cap_off_c;
  logic                     cap_c;
  logic [1:0]               cap_slot_c;

  // State, beat and run counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      r_q     <= r_d;
    end
  end

  // Next state; o_in_ready is high exactly in IDLE/LOAD, so a valid there is an accepted beat
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    r_d      = r_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        accept_c = bus.i_in_valid;
        if (bus.i_in_valid) begin
          if (beat_q == 2'(NCOL - 1)) begin
            state_d = S_RUN;
            beat_d  = '0;
            r_d     = '0;
          end else begin
            state_d = S_LOAD;
            beat_d  = beat_q + 2'd1;
          end
        end
      end
      S_RUN: begin
        if (r_q == RW'(RUN_LAST)) begin
          state_d = S_DONE;
          r_d     = '0;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      S_DONE: begin
        if (bus.i_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result slot k is returned by the datapath at r = 2k + DP_LAT
  assign cap_off_c  = r_q - RW'(DP_LAT);
  assign cap_c      = (state_q == S_RUN) && (r_q >= RW'(DP_LAT)) && !cap_off_c[0];
  assign cap_slot_c = 2'(cap_off_c >> 1);

  // Buffers and registered outputs, driven from the next-state view so they line up with r
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q           <= '0;
      y_q             <= '0;
      bus.o_in_ready  <= 1'b1;
      bus.o_dp_en     <= 1'b0;
      bus.o_dp_e      <= '0;
      bus.o_dp_y      <= '0;
      bus.o_out_valid <= 1'b0;
      bus.o_yhat      <= '0;
    end else begin
      if (accept_c) begin
        col_q[beat_q] <= bus.i_q_col;
        if (beat_q == 2'd0) y_q <= bus.i_y;
      end
      bus.o_in_ready  <= (state_d == S_IDLE) || (state_d == S_LOAD);
      bus.o_out_valid <= (state_d == S_DONE);
      bus.o_dp_en     <= (state_d == S_RUN) && (r_d <= RW'(DP_LAT));
      bus.o_dp_y      <= (state_d == S_RUN) ? y_q : '0;
      if ((state_d == S_RUN) && (r_d >= RW'(1)) && (r_d <= RW'(2 * NCOL)))
        bus.o_dp_e <= col_q[2'((r_d - RW'(1)) >> 1)];
      else
        bus.o_dp_e <= '0;
      for (int k = 0; k < int'(NCOL); k++) begin
        if (cap_c && (cap_slot_c == 2'(k))) bus.o_yhat[k*YW +: YW] <= bus.i_dp_yhat;
      end
    end
  end
endmodule

// File: tb/tb_yhat_sched.sv
// Self-checking bench for yhat_sched with a behavioural cal_yhat stand-in and a frame-level reference model.
module tb_yhat_sched;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  yhat_sched_if bus();

  yhat_sched #(.NCOL(4), .DP_LAT(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // y_hat = sum_n conj(e_n) * y_n, scaled down by 2^28, truncated to 20-bit re/im
  function automatic logic [39:0] cmac(input logic [191:0] e, input logic [191:0] y);
    longint re, im, er, ei, yr, yi;
    re = 0;
    im = 0;
    for (int n = 0; n < 4; n++) begin
      er = longint'($signed(e[48*n +: 24]));
      ei = longint'($signed(e[48*n+24 +: 24]));
      yr = longint'($signed(y[48*n +: 24]));
      yi = longint'($signed(y[48*n+24 +: 24]));
      re += er * yr + ei * yi;
      im += er * yi - ei * yr;
    end
    re = re >>> 28;
    im = im >>> 28;
    return {im[19:0], re[19:0]};
  endfunction

  // cal_yhat stand-in: column on e at r=2k+2 returns at r=2k+5
  logic [39:0] dp_pipe [3];
  always @(posedge i_clk) begin
    if (i_rst) begin
      dp_pipe[0] <= '0;
      dp_pipe[1] <= '0;
      dp_pipe[2] <= '0;
    end else begin
      dp_pipe[0] <= cmac(bus.o_dp_e, bus.o_dp_y);
      dp_pipe[1] <= dp_pipe[0];
      dp_pipe[2] <= dp_pipe[1];
    end
  end
  assign bus.i_dp_yhat = dp_pipe[2];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [191:0] rand192();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [47:0] ent(input int re, input int im);
    return {24'(im), 24'(re)};
  endfunction

  function automatic logic [159:0] model(input logic [3:0][191:0] cols, input logic [191:0] yv);
    logic [159:0] r;
    for (int k = 0; k < 4; k++) r[40*k +: 40] = cmac(cols[k], yv);
    return r;
  endfunction

  // One frame; starts and ends just after a rising edge
  task automatic run_frame(input string name, input logic [3:0][191:0] cols, input logic [191:0] yv,
                           input logic [159:0] exp_yhat, input int gap, input int ready_delay,
                           input bit tie_ready, input bit rst_at6);
    logic seen_valid;
    for (int b = 0; b < 4; b++) begin
      bus.i_in_valid  = 1'b1;
      bus.i_q_col     = cols[b];
      bus.i_y         = (b == 0) ? yv : rand192();
      bus.i_out_ready = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge i_clk);
      check({name, ".beat_in_ready"}, 192'(bus.o_in_ready), 192'(1));
      check({name, ".beat_out_valid"}, 192'(bus.o_out_valid), 192'(0));
      @(posedge i_clk); #1;
      if (b == 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.i_in_valid = 1'b0;
          bus.i_q_col    = rand192();
          bus.i_y        = rand192();
          @(negedge i_clk);
          check({name, ".gap_in_ready"}, 192'(bus.o_in_ready), 192'(1));
          @(posedge i_clk); #1;
        end
      end
    end
    for (int r = 0; r < 12; r++) begin
      bus.i_in_valid  = 1'($urandom_range(0, 1));
      bus.i_q_col     = rand192();
      bus.i_y         = rand192();
      bus.i_out_ready = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge i_clk);
      check($sformatf("%s.dp_en_r%0d", name, r), 192'(bus.o_dp_en), 192'(r <= 5));
      check($sformatf("%s.dp_e_r%0d", name, r), bus.o_dp_e, (r >= 1 && r <= 8) ? cols[(r-1)/2] : '0);
      check($sformatf("%s.dp_y_r%0d", name, r), bus.o_dp_y, yv);
      check($sformatf("%s.run_in_ready_r%0d", name, r), 192'(bus.o_in_ready), 192'(0));
      check($sformatf("%s.run_out_valid_r%0d", name, r), 192'(bus.o_out_valid), 192'(0));
      if (rst_at6 && r == 6) begin
        #2 i_rst = 1'b1;
        #1;
        check({name, ".rst_dp_en"}, 192'(bus.o_dp_en), 192'(0));
        check({name, ".rst_dp_e"}, bus.o_dp_e, '0);
        check({name, ".rst_dp_y"}, bus.o_dp_y, '0);
        check({name, ".rst_yhat"}, 192'(bus.o_yhat), '0);
        check({name, ".rst_out_valid"}, 192'(bus.o_out_valid), 192'(0));
        @(negedge i_clk);
        i_rst          = 1'b0;
        bus.i_in_valid = 1'b0;
        check({name, ".rst_in_ready"}, 192'(bus.o_in_ready), 192'(1));
        seen_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
          @(negedge i_clk);
          seen_valid |= bus.o_out_valid;
        end
        check({name, ".rst_no_out_valid"}, 192'(seen_valid), 192'(0));
        @(posedge i_clk); #1;
        return;
      end
      @(posedge i_clk); #1;
    end
    bus.i_in_valid  = 1'($urandom_range(0, 1));
    bus.i_out_ready = tie_ready ? 1'b1 : 1'b0;
    for (int d = 0; d < ready_delay; d++) begin
      @(negedge i_clk);
      check({name, ".hold_out_valid"}, 192'(bus.o_out_valid), 192'(1));
      check({name, ".hold_yhat"}, 192'(bus.o_yhat), 192'(exp_yhat));
      check({name, ".hold_in_ready"}, 192'(bus.o_in_ready), 192'(0));
      @(posedge i_clk); #1;
      bus.i_in_valid = 1'($urandom_range(0, 1));
      bus.i_q_col    = rand192();
    end
    bus.i_out_ready = 1'b1;
    @(negedge i_clk);
    check({name, ".done_out_valid"}, 192'(bus.o_out_valid), 192'(1));
    check({name, ".done_yhat"}, 192'(bus.o_yhat), 192'(exp_yhat));
    check({name, ".done_in_ready"}, 192'(bus.o_in_ready), 192'(0));
    @(posedge i_clk); #1;
    bus.i_out_ready = tie_ready ? 1'b1 : 1'b0;
    bus.i_in_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][191:0] cols;
    logic [191:0]      yv;
    logic [159:0]      ex;

    bus.i_in_valid  = 1'b0;
    bus.i_q_col     = '0;
    bus.i_y         = '0;
    bus.i_out_ready = 1'b0;
    #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset.dp_en", 192'(bus.o_dp_en), 192'(0));
    check("reset.dp_e", bus.o_dp_e, '0);
    check("reset.dp_y", bus.o_dp_y, '0);
    check("reset.out_valid", 192'(bus.o_out_valid), 192'(0));
    check("reset.yhat", 192'(bus.o_yhat), '0);
    i_rst = 1'b0;
    #1 check("reset.in_ready", 192'(bus.o_in_ready), 192'(1));
    @(posedge i_clk); #1;

    // Single unit entry: slot0 = {re 16, im -32}
    cols = '0;
    cols[0][47:0] = ent(65536, 0);
    yv = '0;
    yv[47:0] = ent(65536, -131072);
    ex = '0;
    ex[39:0] = {20'hFFFE0, 20'h00010};
    run_frame("unit", cols, yv, ex, 0, 0, 1'b0, 1'b0);

    // Scaled identity columns: slot k = 16*(k+1)
    cols = '0;
    yv   = '0;
    ex   = '0;
    for (int k = 0; k < 4; k++) begin
      cols[k][48*k +: 48] = ent(65536, 0);
      yv[48*k +: 48]      = ent(65536 * (k + 1), 0);
      ex[40*k +: 40]      = {20'd0, 20'(16 * (k + 1))};
    end
    run_frame("ident", cols, yv, ex, 0, 2, 1'b0, 1'b0);
    run_frame("ident_gap", cols, yv, ex, 3, 10, 1'b0, 1'b0);

    // Reset mid-RUN, then a clean frame
    begin
      logic [3:0][191:0] rc;
      logic [191:0]      ry;
      for (int k = 0; k < 4; k++) rc[k] = rand192();
      ry = rand192();
      run_frame("abort", rc, ry, model(rc, ry), 0, 0, 1'b0, 1'b1);
    end
    run_frame("after_rst", cols, yv, ex, 0, 0, 1'b0, 1'b0);

    // Back-to-back random frames with ready tied high
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) cols[k] = rand192();
      yv = rand192();
      run_frame($sformatf("b2b%0d", f), cols, yv, model(cols, yv), 0, 0, 1'b1, 1'b0);
    end
    bus.i_out_ready = 1'b0;

    // Random frames with random gaps and output stalls
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) cols[k] = rand192();
      yv = rand192();
      run_frame($sformatf("rnd%0d", f), cols, yv, model(cols, yv),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
